fifo_param: RTL
===============

FIFO_PARAM -- requirements
Module: fifo_param

Interface
REQ-001 Parameter WIDTH, default 8: data word width in bits (>=1).
REQ-002 Parameter DEPTH, default 16: number of storage entries (power of 2, >=4).
REQ-003 Parameter AF_LEVEL, default DEPTH-2: almost_full asserts at occupancy >= AF_LEVEL.
REQ-004 Parameter AE_LEVEL, default 2: almost_empty asserts at occupancy <= AE_LEVEL.
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 rst  input  1  synchronous reset, active-low.
REQ-007 din  input  WIDTH  write data, sampled on the rising edge when we=1.
REQ-008 we  input  1  write request.
REQ-009 re  input  1  read request.
REQ-010 dout  output  WIDTH  registered read data.
REQ-011 full  output  1  occupancy == DEPTH.
REQ-012 empty  output  1  occupancy == 0.
REQ-013 almost_full  output  1  occupancy >= AF_LEVEL.
REQ-014 almost_empty  output  1  occupancy <= AE_LEVEL.
REQ-015 count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
REQ-016 overflow  output  1  sticky: write attempted while full and not accepted.
REQ-017 underflow  output  1  sticky: read attempted while empty.

Function
REQ-018 Storage SHALL be DEPTH x WIDTH registers with write pointer wp and read pointer rp, each $clog2(DEPTH) bits, wrapping from DEPTH-1 to 0.
REQ-019 Write accepted when we=1 and (full=0, or full=1 with re=1 accepted same cycle); accepted write stores din at wp, wp increments.
REQ-020 Read accepted when re=1 and empty=0; dout loads mem[rp] on that edge (1-cycle latency), rp increments.
REQ-021 dout SHALL hold its last value in cycles with no accepted read.
REQ-022 count update per edge: +1 on write-only, -1 on read-only, unchanged on both or neither.
REQ-023 Simultaneous we=1, re=1 when empty: read rejected (underflow set), write accepted, count becomes 1.
REQ-024 Simultaneous we=1, re=1 when full: both accepted, count stays DEPTH, overflow not set.
REQ-025 we=1 while full with re=0: write dropped, memory and wp unchanged, overflow set to 1.
REQ-026 re=1 while empty: rp and dout unchanged, underflow set to 1.
REQ-027 overflow/underflow SHALL remain 1 until reset.
REQ-028 full, empty, almost_full, almost_empty SHALL be decoded combinationally from registered count and reflect state after the most recent edge.
REQ-029 Wrap-around SHALL be transparent: data order preserved across any number of pointer wraps.

Reset
REQ-030 On a rising edge with rst=0: wp=0, rp=0, count=0, dout=0, overflow=0, underflow=0; empty=1, almost_empty=1, full=0, almost_full=0.
REQ-031 Reset SHALL override we/re in the same cycle; reset mid-operation discards all stored data (memory contents need not be cleared).
REQ-032 Outputs SHALL be undefined only before the first reset edge.

Verification
REQ-033 Reset, then write 0..15 on consecutive edges (DEPTH=16) -> count=16, full=1, almost_full asserted at count=14, empty=0.
REQ-034 From full, read 16 times -> dout sequence 0..15 one cycle after each re, empty=1 after last, almost_empty at count<=2, underflow=0.
REQ-035 Write 17 words with no read -> 17th dropped, overflow=1, count=16; subsequent 16 reads return 0..15.
REQ-036 Read when empty -> underflow=1, dout unchanged, count=0; remains 1 after further normal traffic until rst=0.
REQ-037 Fill to 16, then 40 cycles of we=re=1 with din incrementing from 16 -> count stays 16, dout yields 0,1,2,... in order through pointer wraps, no overflow.
REQ-038 Reset asserted with count=9 and we=1 -> next edge count=0, empty=1, dout=0, flags cleared; written word not stored.

Source files
------------

// File: rtl/fifo_param.sv
// Single-clock synchronous FIFO with registered read data, occupancy count and sticky error flags.
// Read data appears one edge after an accepted read; writes to a full FIFO are dropped unless a read frees the slot in the same cycle.
module fifo_param #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [WIDTH-1:0]         din,
  input  logic                     we,
  input  logic                     re,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wp;
  logic [AW-1:0]    rp;
  logic             wr_ok;
  logic             rd_ok;

  assign full         = (count == CW'(DEPTH));
  assign empty        = (count == '0);
  assign almost_full  = (count >= CW'(AF_LEVEL));
  assign almost_empty = (count <= CW'(AE_LEVEL));

  // A full FIFO still takes a write when the same-cycle read frees a slot.
  assign rd_ok = re && !empty;
  assign wr_ok = we && (!full || rd_ok);

  // Storage is not reset; stale entries are unreachable once the pointers clear.
  always_ff @(posedge clk) begin
    if (rst && wr_ok) begin
      mem[wp] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wp        <= '0;
      rp        <= '0;
      count     <= '0;
      dout      <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_ok) begin
        wp <= wp + 1'b1;
      end
      if (rd_ok) begin
        dout <= mem[rp];
        rp   <= rp + 1'b1;
      end
      if (wr_ok && !rd_ok) begin
        count <= count + 1'b1;
      end else if (rd_ok && !wr_ok) begin
        count <= count - 1'b1;
      end
      if (we && !wr_ok) begin
        overflow <= 1'b1;
      end
      if (re && empty) begin
        underflow <= 1'b1;
      end
    end
  end

endmodule
